// File: rtl/uart_tx_arb.sv
// Two-requester round-robin arbiter feeding a single UART transmitter.
// Grants one byte per frame, waits for tx_done (or a timeout), then enforces an inter-frame gap.
module uart_tx_arb #(
    parameter int GAP_CYCLES = 2,
    parameter int TIMEOUT    = 4095
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       req0,
    input  logic [7:0] din0,
    output logic       gnt0,
    input  logic       req1,
    input  logic [7:0] din1,
    output logic       gnt1,
    output logic       tx_start,
    output logic [7:0] tx_din,
    input  logic       tx_done,
    output logic       busy,
    output logic       owner,
    input  logic       clr_err,
    output logic       timeout_err
);

    localparam logic [11:0] TIMEOUT_CNT = 12'(TIMEOUT);
    localparam logic [7:0]  GAP_LAST    = 8'(GAP_CYCLES - 1);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        START = 2'd1,
        BUSY  = 2'd2,
        GAP   = 2'd3
    } state_t;

    state_t      state_q;
    logic [11:0] busy_cnt_q;
    logic [7:0]  gap_cnt_q;
    logic        gnt0_q;
    logic        gnt1_q;
    logic        tx_start_q;
    logic [7:0]  tx_din_q;
    logic        busy_q;
    logic        owner_q;
    logic        err_q;

    // On a tie the requester that did not win last time gets the grant.
    logic win_d;
    assign win_d = (req0 && req1) ? ~owner_q : req1;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q    <= IDLE;
            busy_cnt_q <= 12'd0;
            gap_cnt_q  <= 8'd0;
            gnt0_q     <= 1'b0;
            gnt1_q     <= 1'b0;
            tx_start_q <= 1'b0;
            tx_din_q   <= 8'h00;
            busy_q     <= 1'b0;
            owner_q    <= 1'b1;
            err_q      <= 1'b0;
        end else begin
            gnt0_q     <= 1'b0;
            gnt1_q     <= 1'b0;
            tx_start_q <= 1'b0;
            if (clr_err) begin
                err_q <= 1'b0;
            end
            case (state_q)
                IDLE: begin
                    if (req0 || req1) begin
                        state_q    <= START;
                        owner_q    <= win_d;
                        tx_din_q   <= win_d ? din1 : din0;
                        gnt0_q     <= ~win_d;
                        gnt1_q     <= win_d;
                        tx_start_q <= 1'b1;
                        busy_q     <= 1'b1;
                    end
                end
                START: begin
                    state_q    <= BUSY;
                    busy_cnt_q <= 12'd1;
                end
                BUSY: begin
                    // A tx_done arriving on the timeout cycle still counts as a clean finish.
                    if (tx_done || busy_cnt_q == TIMEOUT_CNT) begin
                        if (!tx_done) begin
                            err_q <= 1'b1;
                        end
                        busy_cnt_q <= 12'd0;
                        if (GAP_CYCLES == 0) begin
                            state_q <= IDLE;
                            busy_q  <= 1'b0;
                        end else begin
                            state_q   <= GAP;
                            gap_cnt_q <= GAP_LAST;
                        end
                    end else begin
                        busy_cnt_q <= busy_cnt_q + 12'd1;
                    end
                end
                GAP: begin
                    if (gap_cnt_q == 8'd0) begin
                        state_q <= IDLE;
                        busy_q  <= 1'b0;
                    end else begin
                        gap_cnt_q <= gap_cnt_q - 8'd1;
                    end
                end
                default: begin
                    state_q <= IDLE;
                    busy_q  <= 1'b0;
                end
            endcase
        end
    end

    assign gnt0        = gnt0_q;
    assign gnt1        = gnt1_q;
    assign tx_start    = tx_start_q;
    assign tx_din      = tx_din_q;
    assign busy        = busy_q;
    assign owner       = owner_q;
    assign timeout_err = err_q;

endmodule

// File: tb/tb_uart_tx_arb.sv
// Bench for uart_tx_arb: a cycle table on a GAP=2/TIMEOUT=20 instance, then
// directed sequences for fairness, timeout, reset abort and a zero-gap instance.
module tb_uart_tx_arb;

    logic clk;
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // instance A: GAP_CYCLES=2, TIMEOUT=20
    logic       rst_a, req0_a, req1_a, done_a, clr_a;
    logic [7:0] din0_a, din1_a, tx_din_a;
    logic       gnt0_a, gnt1_a, tx_start_a, busy_a, owner_a, err_a;

    // instance B: GAP_CYCLES=0, TIMEOUT=20
    logic       rst_b, req0_b, req1_b, done_b, clr_b;
    logic [7:0] din0_b, din1_b, tx_din_b;
    logic       gnt0_b, gnt1_b, tx_start_b, busy_b, owner_b, err_b;

    uart_tx_arb #(.GAP_CYCLES(2), .TIMEOUT(20)) dut_a (
        .clk(clk), .rst(rst_a),
        .req0(req0_a), .din0(din0_a), .gnt0(gnt0_a),
        .req1(req1_a), .din1(din1_a), .gnt1(gnt1_a),
        .tx_start(tx_start_a), .tx_din(tx_din_a), .tx_done(done_a),
        .busy(busy_a), .owner(owner_a), .clr_err(clr_a), .timeout_err(err_a)
    );

    uart_tx_arb #(.GAP_CYCLES(0), .TIMEOUT(20)) dut_b (
        .clk(clk), .rst(rst_b),
        .req0(req0_b), .din0(din0_b), .gnt0(gnt0_b),
        .req1(req1_b), .din1(din1_b), .gnt1(gnt1_b),
        .tx_start(tx_start_b), .tx_din(tx_din_b), .tx_done(done_b),
        .busy(busy_b), .owner(owner_b), .clr_err(clr_b), .timeout_err(err_b)
    );

    int n_cmp = 0;
    int n_err = 0;

    typedef struct {
        logic       rst, req0, req1, done, clr;
        logic [7:0] din0, din1;
        logic       e_gnt0, e_gnt1, e_start, e_busy, e_owner, e_err;
        logic [7:0] e_din;
    } vec_t;

    vec_t vecs[$];

    function automatic vec_t mk(input logic rst, input logic r0, input logic [7:0] d0,
                                input logic r1, input logic [7:0] d1,
                                input logic done, input logic clr,
                                input logic g0, input logic g1, input logic st,
                                input logic bz, input logic own, input logic er,
                                input logic [7:0] td);
        vec_t v;
        v.rst = rst; v.req0 = r0; v.din0 = d0; v.req1 = r1; v.din1 = d1;
        v.done = done; v.clr = clr;
        v.e_gnt0 = g0; v.e_gnt1 = g1; v.e_start = st; v.e_busy = bz;
        v.e_owner = own; v.e_err = er; v.e_din = td;
        return v;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Returns the number of falling edges waited until tx_start is seen high.
    task automatic wait_start(input bit sel, output int d);
        d = 0;
        while (!(sel ? tx_start_b : tx_start_a) && d < 40) begin
            @(negedge clk);
            d++;
        end
        if (!(sel ? tx_start_b : tx_start_a)) begin
            n_cmp++;
            n_err++;
            $display("FAIL start_timeout: got no tx_start expected tx_start within 40 cycles");
        end
    endtask

    task automatic reset_a();
        rst_a = 1'b1;
        @(negedge clk);
        rst_a = 1'b0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got no finish expected finish before 200us");
        $fatal(1, "watchdog");
    end

    initial begin
        int d;
        rst_a = 1'b1; req0_a = 0; req1_a = 0; done_a = 0; clr_a = 0; din0_a = 0; din1_a = 0;
        rst_b = 1'b1; req0_b = 0; req1_b = 0; done_b = 0; clr_b = 0; din0_b = 0; din1_b = 0;

        // rst r0 d0 r1 d1 done clr | gnt0 gnt1 start busy owner err tx_din
        vecs.push_back(mk(1, 0, 8'h00, 0, 8'h00, 0, 0,  0, 0, 0, 0, 1, 0, 8'h00));
        vecs.push_back(mk(1, 1, 8'hA5, 1, 8'h22, 1, 0,  0, 0, 0, 0, 1, 0, 8'h00));
        vecs.push_back(mk(0, 0, 8'h00, 0, 8'h00, 0, 0,  0, 0, 0, 0, 1, 0, 8'h00));
        vecs.push_back(mk(0, 0, 8'h00, 0, 8'h00, 1, 0,  0, 0, 0, 0, 1, 0, 8'h00));
        vecs.push_back(mk(0, 1, 8'hA5, 0, 8'h00, 0, 0,  1, 0, 1, 1, 0, 0, 8'hA5));
        vecs.push_back(mk(0, 0, 8'h00, 0, 8'h00, 0, 0,  0, 0, 0, 1, 0, 0, 8'hA5));
        for (int k = 0; k < 9; k++)
            vecs.push_back(mk(0, 0, 8'h00, 0, 8'h00, 0, 0,  0, 0, 0, 1, 0, 0, 8'hA5));
        // tx_done on BUSY count 10, then two GAP cycles before IDLE
        vecs.push_back(mk(0, 0, 8'h00, 0, 8'h00, 1, 0,  0, 0, 0, 1, 0, 0, 8'hA5));
        vecs.push_back(mk(0, 0, 8'h00, 1, 8'h77, 0, 0,  0, 0, 0, 1, 0, 0, 8'hA5));
        vecs.push_back(mk(0, 0, 8'h00, 0, 8'h00, 0, 0,  0, 0, 0, 0, 0, 0, 8'hA5));
        vecs.push_back(mk(0, 0, 8'h00, 0, 8'h00, 0, 0,  0, 0, 0, 0, 0, 0, 8'hA5));
        // tie with owner=0: requester 1 wins, then requester 0
        vecs.push_back(mk(0, 1, 8'h11, 1, 8'h22, 0, 0,  0, 1, 1, 1, 1, 0, 8'h22));
        vecs.push_back(mk(0, 1, 8'h11, 0, 8'h00, 1, 0,  0, 0, 0, 1, 1, 0, 8'h22));
        vecs.push_back(mk(0, 1, 8'h11, 0, 8'h00, 0, 0,  0, 0, 0, 1, 1, 0, 8'h22));
        vecs.push_back(mk(0, 1, 8'h11, 0, 8'h00, 1, 0,  0, 0, 0, 1, 1, 0, 8'h22));
        vecs.push_back(mk(0, 1, 8'h11, 0, 8'h00, 0, 0,  0, 0, 0, 1, 1, 0, 8'h22));
        vecs.push_back(mk(0, 1, 8'h11, 0, 8'h00, 0, 0,  0, 0, 0, 0, 1, 0, 8'h22));
        vecs.push_back(mk(0, 1, 8'h11, 0, 8'h00, 0, 0,  1, 0, 1, 1, 0, 0, 8'h11));
        vecs.push_back(mk(0, 0, 8'h00, 0, 8'h00, 0, 0,  0, 0, 0, 1, 0, 0, 8'h11));

        @(negedge clk);
        for (int i = 0; i < vecs.size(); i++) begin
            rst_a = vecs[i].rst; req0_a = vecs[i].req0; din0_a = vecs[i].din0;
            req1_a = vecs[i].req1; din1_a = vecs[i].din1;
            done_a = vecs[i].done; clr_a = vecs[i].clr;
            @(negedge clk);
            chk($sformatf("vec%0d", i),
                {18'd0, gnt0_a, gnt1_a, tx_start_a, busy_a, owner_a, err_a, tx_din_a},
                {18'd0, vecs[i].e_gnt0, vecs[i].e_gnt1, vecs[i].e_start, vecs[i].e_busy,
                 vecs[i].e_owner, vecs[i].e_err, vecs[i].e_din});
        end
        req0_a = 0; req1_a = 0; done_a = 0;

        // Fairness: both held, tx_done on BUSY count 5, grants 0,1,0,1.
        reset_a();
        req0_a = 1; din0_a = 8'hA0; req1_a = 1; din1_a = 8'hB1;
        for (int f = 0; f < 4; f++) begin
            wait_start(1'b0, d);
            // done cycle, then GAP, GAP, IDLE, START: 3 more edges after the done cycle
            if (f > 0) chk($sformatf("rr_gap%0d", f), d, 3);
            chk($sformatf("rr_gnt%0d", f), {gnt0_a, gnt1_a}, (f % 2 == 0) ? 2'b10 : 2'b01);
            chk($sformatf("rr_din%0d", f), tx_din_a, (f % 2 == 0) ? 8'hA0 : 8'hB1);
            repeat (5) @(negedge clk);
            done_a = 1;
            @(negedge clk);
            done_a = 0;
        end
        req0_a = 0; req1_a = 0;
        repeat (2) @(negedge clk);
        chk("rr_idle_busy", busy_a, 0);

        // Timeout after 20 BUSY cycles, then clear.
        req0_a = 1; din0_a = 8'h5A;
        wait_start(1'b0, d);
        req0_a = 0;
        repeat (20) @(negedge clk);
        chk("to_pre_err", err_a, 0);
        @(negedge clk);
        chk("to_err_set", err_a, 1);
        chk("to_gap_busy", busy_a, 1);
        repeat (2) @(negedge clk);
        chk("to_idle_busy", busy_a, 0);
        chk("to_err_sticky", err_a, 1);
        clr_a = 1;
        @(negedge clk);
        clr_a = 0;
        chk("to_err_clr", err_a, 0);

        // clr_err coinciding with a new timeout leaves the flag set.
        req0_a = 1;
        wait_start(1'b0, d);
        req0_a = 0;
        repeat (20) @(negedge clk);
        clr_a = 1;
        @(negedge clk);
        clr_a = 0;
        chk("clr_vs_to", err_a, 1);
        repeat (2) @(negedge clk);

        // Reset during BUSY, then requester 1 alone.
        req0_a = 1; din0_a = 8'h66;
        wait_start(1'b0, d);
        req0_a = 0;
        repeat (3) @(negedge clk);
        rst_a = 1;
        #1;
        chk("rst_outs", {gnt0_a, gnt1_a, tx_start_a, busy_a, err_a, tx_din_a}, 13'd0);
        chk("rst_owner", owner_a, 1);
        @(negedge clk);
        rst_a = 0; req1_a = 1; din1_a = 8'hC3;
        wait_start(1'b0, d);
        chk("post_rst_lat", d, 1);
        chk("post_rst_gnt", {gnt0_a, gnt1_a, owner_a, tx_din_a}, {3'b011, 8'hC3});
        req1_a = 0;
        @(negedge clk);
        done_a = 1;
        @(negedge clk);
        done_a = 0;
        repeat (2) @(negedge clk);

        // tx_done on the very cycle the count hits TIMEOUT: no error.
        reset_a();
        req0_a = 1;
        wait_start(1'b0, d);
        req0_a = 0;
        repeat (20) @(negedge clk);
        done_a = 1;
        @(negedge clk);
        done_a = 0;
        chk("done_at_to_err", err_a, 0);
        chk("done_at_to_busy", busy_a, 1);
        repeat (2) @(negedge clk);
        chk("done_at_to_idle", busy_a, 0);

        // Zero gap: BUSY -> IDLE -> START, tx_start two cycles after tx_done.
        rst_b = 1;
        @(negedge clk);
        rst_b = 0; req0_b = 1; din0_b = 8'h0F; req1_b = 1; din1_b = 8'hF0;
        wait_start(1'b1, d);
        chk("g0_first", {gnt0_b, gnt1_b, tx_din_b}, {2'b10, 8'h0F});
        repeat (3) @(negedge clk);
        done_b = 1;
        @(negedge clk);
        done_b = 0;
        chk("g0_idle", busy_b, 0);
        wait_start(1'b1, d);
        chk("g0_lat", d, 1);
        chk("g0_second", {gnt0_b, gnt1_b, owner_b, tx_din_b}, {3'b011, 8'hF0});
        req0_b = 0; req1_b = 0;
        repeat (2) @(negedge clk);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
